// File: rtl/spi_icb_bridge.sv
// spi_icb_bridge: SPI mode-0 slave that turns each frame into a single ICB strobe.
// A frame is: rw bit (1 = read), aw address bits, then dw data bits, all MSB first.
// Every SPI pin is synchronized into clk. clk must run at least 8x faster than sclk.
// Optional feature: defining SPI_ICB_ABORT_CNT_EN adds the abort_cnt output.
// abort_cnt is a saturating count of frames that were cut short.
module spi_icb_bridge #(
  parameter int aw = 8,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_sclk,
  input  logic          spi_csn,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  output logic          icb_wr,
  output logic [aw-1:0] icb_wadr,
  output logic [dw-1:0] icb_wdata,
  output logic          icb_rd,
  output logic [aw-1:0] icb_radr,
  input  logic [dw-1:0] icb_rdata,
  output logic          busy
`ifdef SPI_ICB_ABORT_CNT_EN
  ,
  output logic [7:0]    abort_cnt
`endif
);

  localparam int cw = $clog2(aw + dw + 2);
  localparam logic [cw-1:0] addr_last = cw'(aw);
  localparam logic [cw-1:0] data_last = cw'(dw - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    RDREQ = 3'd2,
    RDCAP = 3'd3,
    DATA  = 3'd4,
    WRREQ = 3'd5,
    WAIT  = 3'd6
  } state_t;

  state_t state, state_next;

  // Synchronizer stages plus one delayed copy for edge detection.
  logic sclk_s1, sclk_s2, sclk_d;
  logic csn_s1, csn_s2, csn_d;
  logic mosi_s1, mosi_s2;

  // prime[1] goes high once real pin values have reached csn_s2 after reset.
  logic [1:0] prime;
  // armed means csn has been seen high since reset.
  // A frame that was already running when reset was released is therefore never picked up halfway.
  logic armed;

  logic sclk_rise, sclk_fall, csn_fall;
  logic addr_done, data_done;

  logic [aw-1:0] hdr_shift;
  logic [aw:0]   hdr_next;
  logic [aw-1:0] addr_reg;
  logic          rw;
  logic [dw-2:0] data_shift;
  logic [dw-1:0] data_next;
  logic [dw-1:0] tx_shift;
  logic [cw-1:0] bit_cnt;

  // Bring the asynchronous SPI pins into the clk domain.
  // The csn stages reset to 1 so that reset looks like "not selected".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      csn_s1  <= 1'b1;
      csn_s2  <= 1'b1;
      csn_d   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      prime   <= 2'b00;
    end else begin
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      csn_s1  <= spi_csn;
      csn_s2  <= csn_s1;
      csn_d   <= csn_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
      prime   <= {prime[0], 1'b1};
    end
  end

  // Set armed once csn is seen high after the synchronizer has filled with real pin values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (prime[1] && csn_s2) begin
      armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign csn_fall  = armed & csn_d & ~csn_s2;

  // hdr_next[aw] holds rw on the final header bit.
  assign hdr_next  = {hdr_shift, mosi_s2};
  assign data_next = {data_shift, mosi_s2};
  assign addr_done = (state == ADDR) && sclk_rise && (bit_cnt == addr_last);
  assign data_done = (state == DATA) && sclk_rise && (bit_cnt == data_last);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // csn high aborts a shifting phase, but a strobe that has already been issued is allowed to finish.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (csn_fall) state_next = ADDR;
      end
      ADDR: begin
        if (csn_s2)         state_next = IDLE;
        else if (addr_done) state_next = hdr_shift[aw-1] ? RDREQ : DATA;
      end
      RDREQ: begin
        state_next = csn_s2 ? IDLE : RDCAP;
      end
      RDCAP: begin
        state_next = csn_s2 ? IDLE : DATA;
      end
      DATA: begin
        if (csn_s2)         state_next = IDLE;
        else if (data_done) state_next = rw ? WAIT : WRREQ;
      end
      WRREQ: begin
        state_next = csn_s2 ? IDLE : WAIT;
      end
      WAIT: begin
        if (csn_s2) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: bit counter, receive shifters, read-data shifter and the strobe address/data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      hdr_shift  <= '0;
      addr_reg   <= '0;
      rw         <= 1'b0;
      data_shift <= '0;
      tx_shift   <= '0;
      icb_wadr   <= '0;
      icb_wdata  <= '0;
      icb_radr   <= '0;
    end else begin
      // The counter restarts at every state change.
      // It therefore counts header bits in ADDR and data bits in DATA.
      if (state_next != state) begin
        bit_cnt <= '0;
      end else if (sclk_rise && (state == ADDR || state == DATA)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == IDLE) begin
        hdr_shift  <= '0;
        data_shift <= '0;
      end

      if (state == ADDR && sclk_rise) begin
        hdr_shift <= hdr_next[aw-1:0];
      end

      if (addr_done) begin
        rw       <= hdr_next[aw];
        addr_reg <= hdr_next[aw-1:0];
      end

      // The address and data outputs only change together with the strobe that carries them.
      if (state == ADDR && state_next == RDREQ) begin
        icb_radr <= hdr_next[aw-1:0];
      end

      if (state == DATA && state_next == WRREQ) begin
        icb_wadr  <= addr_reg;
        icb_wdata <= data_next;
      end

      if (state == DATA && !rw && sclk_rise) begin
        data_shift <= data_next[dw-2:0];
      end

      // The fall that ends the last address bit arrives while already in DATA.
      // Shifting only starts after the first data rise, so the MSB is held for that rise.
      if (state == RDCAP) begin
        tx_shift <= icb_rdata;
      end else if (state == DATA && rw && sclk_fall && bit_cnt != '0) begin
        tx_shift <= tx_shift << 1;
      end
    end
  end

  // Output decode from the current state.
  // During RDCAP, miso takes the MSB straight from icb_rdata because the shifter is still being loaded.
  always_comb begin
    busy        = (state != IDLE);
    icb_wr      = (state == WRREQ);
    icb_rd      = (state == RDREQ);
    spi_miso_oe = rw && (state == RDCAP || state == DATA || state == WAIT);
    spi_miso    = 1'b0;
    if (spi_miso_oe) begin
      spi_miso = (state == RDCAP) ? icb_rdata[dw-1] : tx_shift[dw-1];
    end
  end

`ifdef SPI_ICB_ABORT_CNT_EN
  // Count frames cut short during ADDR or DATA. The count saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_cnt <= 8'd0;
    end else if ((state == ADDR || state == DATA) && csn_s2 && abort_cnt != 8'hFF) begin
      abort_cnt <= abort_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_icb_bridge.sv
// Testbench for spi_icb_bridge.
// Expected strobes are queued as frames are sent, and a negedge monitor checks them off as the DUT issues them.
// The same file builds with or without SPI_ICB_ABORT_CNT_EN.
module tb_spi_icb_bridge;

  localparam int SH = 60;  // sclk half period in ns: 6 clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_csn = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic       icb_wr, icb_rd, busy;
  logic [7:0] icb_wadr, icb_wdata, icb_radr;
  logic [7:0] icb_rdata = 8'h00;
`ifdef SPI_ICB_ABORT_CNT_EN
  logic [7:0] abort_cnt;
`endif

  spi_icb_bridge #(.aw(8), .dw(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk    (spi_sclk),
    .spi_csn     (spi_csn),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .icb_wr      (icb_wr),
    .icb_wadr    (icb_wadr),
    .icb_wdata   (icb_wdata),
    .icb_rd      (icb_rd),
    .icb_radr    (icb_radr),
    .icb_rdata   (icb_rdata),
    .busy        (busy)
`ifdef SPI_ICB_ABORT_CNT_EN
    ,
    .abort_cnt   (abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_rd;
    logic [7:0] adr;
    logic [7:0] data;
  } strobe_t;

  strobe_t    exp_q[$];
  strobe_t    mon_e;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         wr_seen = 0;
  int         rd_seen = 0;
  logic [7:0] rdata_value = 8'h00;
  logic       prev_wr = 1'b0;
  logic       prev_rd = 1'b0;

  // Bus slave model: read data is valid in the cycle after icb_rd and zero at all other times.
  always @(posedge clk) begin
    icb_rdata <= icb_rd ? rdata_value : 8'h00;
  end

  // Strobe monitor and scoreboard.
  always @(negedge clk) begin
    if (icb_wr || icb_rd) begin
      tests_run++;
      if (icb_wr && icb_rd) begin
        tests_failed++;
        $display("FAIL strobe_excl: wr=%b rd=%b required not both", icb_wr, icb_rd);
      end else if ((icb_wr && prev_wr) || (icb_rd && prev_rd)) begin
        tests_failed++;
        $display("FAIL strobe_width: strobe held >1 clk, required 1 clk");
      end else if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_strobe: wr=%b rd=%b wadr=%h radr=%h, required none", icb_wr, icb_rd, icb_wadr, icb_radr);
      end else begin
        mon_e = exp_q.pop_front();
        if (icb_wr) begin
          wr_seen++;
          $display("[TB] icb_wr adr=%h data=%h", icb_wadr, icb_wdata);
          if (mon_e.is_rd || icb_wadr !== mon_e.adr || icb_wdata !== mon_e.data) begin
            tests_failed++;
            $display("FAIL wr_strobe: got wr adr=%h data=%h, required is_rd=%0d adr=%h data=%h",
                     icb_wadr, icb_wdata, mon_e.is_rd, mon_e.adr, mon_e.data);
          end
        end else begin
          rd_seen++;
          $display("[TB] icb_rd adr=%h", icb_radr);
          if (!mon_e.is_rd || icb_radr !== mon_e.adr) begin
            tests_failed++;
            $display("FAIL rd_strobe: got rd adr=%h, required is_rd=%0d adr=%h", icb_radr, mon_e.is_rd, mon_e.adr);
          end
        end
      end
    end
    prev_wr = icb_wr;
    prev_rd = icb_rd;
  end

  // One SPI mode-0 frame.
  // miso, busy and oe are sampled just before each sclk rise; the last sample is returned.
  task automatic spi_xfer(input logic [31:0] tx, input int nbits, input int gap,
                          output logic [31:0] rx, output logic busy_last, output logic oe_last);
    rx = 32'h0;
    busy_last = 1'b0;
    oe_last = 1'b0;
    spi_csn = 1'b0;
    #(SH);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[nbits-1-i];
      #(SH);
      rx = {rx[30:0], spi_miso};
      busy_last = busy;
      oe_last = spi_miso_oe;
      spi_sclk = 1'b1;
      #(SH);
      spi_sclk = 1'b0;
    end
    #(SH);
    spi_csn = 1'b1;
    spi_mosi = 1'b0;
    #(gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #40;
    tests_run++;
    if ({spi_miso, spi_miso_oe, icb_wr, icb_rd, busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: miso/oe/wr/rd/busy=%b required 00000", {spi_miso, spi_miso_oe, icb_wr, icb_rd, busy});
    end
    tests_run++;
    if ({icb_wadr, icb_wdata, icb_radr} !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: wadr=%h wdata=%h radr=%h required 0", icb_wadr, icb_wdata, icb_radr);
    end
`ifdef SPI_ICB_ABORT_CNT_EN
    tests_run++;
    if (abort_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_abort_cnt: got %0d required 0", abort_cnt);
    end
`endif
    rst_n = 1'b1;
    #100;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_busy: got %b required 0", busy);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_write();
    logic [31:0] rx;
    logic bl, ol;
    int w0, r0;
    w0 = wr_seen; r0 = rd_seen;
    exp_q.push_back('{is_rd: 1'b0, adr: 8'h25, data: 8'hA5});
    spi_xfer({15'h0, 1'b0, 8'h25, 8'hA5}, 17, 4*SH, rx, bl, ol);
    tests_run++;
    if (wr_seen - w0 !== 1 || rd_seen - r0 !== 0) begin
      tests_failed++;
      $display("FAIL write_count: wr=%0d rd=%0d required wr=1 rd=0", wr_seen - w0, rd_seen - r0);
    end
    tests_run++;
    if (bl !== 1'b1 || ol !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_busy_oe: busy=%b oe=%b during frame, required 1 0", bl, ol);
    end
    tests_run++;
    if (busy !== 1'b0 || icb_wadr !== 8'h25 || icb_wdata !== 8'hA5) begin
      tests_failed++;
      $display("FAIL write_hold: busy=%b wadr=%h wdata=%h required 0 25 a5", busy, icb_wadr, icb_wdata);
    end
    $display("[TB] write frame 25/a5 done");
  endtask

  task automatic test_read(input logic [7:0] adr, input logic [7:0] val);
    logic [31:0] rx;
    logic bl, ol;
    int w0, r0;
    w0 = wr_seen; r0 = rd_seen;
    rdata_value = val;
    exp_q.push_back('{is_rd: 1'b1, adr: adr, data: val});
    spi_xfer({15'h0, 1'b1, adr, 8'h00}, 17, 4*SH, rx, bl, ol);
    tests_run++;
    if (rx[7:0] !== val) begin
      tests_failed++;
      $display("FAIL read_miso: got %b required %b", rx[7:0], val);
    end
    tests_run++;
    if (wr_seen - w0 !== 0 || rd_seen - r0 !== 1) begin
      tests_failed++;
      $display("FAIL read_count: wr=%0d rd=%0d required wr=0 rd=1", wr_seen - w0, rd_seen - r0);
    end
    tests_run++;
    if (ol !== 1'b1 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || icb_radr !== adr) begin
      tests_failed++;
      $display("FAIL read_oe_hold: oe_in=%b oe_after=%b miso_after=%b radr=%h required 1 0 0 %h",
               ol, spi_miso_oe, spi_miso, icb_radr, adr);
    end
    $display("[TB] read frame adr=%h miso=%h", adr, rx[7:0]);
  endtask

  task automatic test_abort(input int nbits);
    logic [31:0] rx;
    logic bl, ol;
    int w0, r0;
`ifdef SPI_ICB_ABORT_CNT_EN
    logic [7:0] a0;
    a0 = abort_cnt;
`endif
    w0 = wr_seen; r0 = rd_seen;
    spi_xfer({15'h0, 1'b0, 8'h5C, 8'h3F}, nbits, 4*SH, rx, bl, ol);
    tests_run++;
    if (wr_seen !== w0 || rd_seen !== r0 || bl !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_%0d: strobes wr=%0d rd=%0d busy_in=%b busy_after=%b required 0 0 1 0",
               nbits, wr_seen - w0, rd_seen - r0, bl, busy);
    end
`ifdef SPI_ICB_ABORT_CNT_EN
    tests_run++;
    if (abort_cnt !== a0 + 8'd1) begin
      tests_failed++;
      $display("FAIL abort_cnt_%0d: got %0d required %0d", nbits, abort_cnt, a0 + 8'd1);
    end
`endif
    $display("[TB] abort after %0d bits done", nbits);
  endtask

  task automatic test_overlong();
    logic [31:0] rx;
    logic bl, ol;
    int w0;
    w0 = wr_seen;
    exp_q.push_back('{is_rd: 1'b0, adr: 8'h5A, data: 8'hC3});
    spi_xfer({10'h0, 1'b0, 8'h5A, 8'hC3, 5'b10111}, 22, 4*SH, rx, bl, ol);
    tests_run++;
    if (wr_seen - w0 !== 1 || icb_wadr !== 8'h5A || icb_wdata !== 8'hC3) begin
      tests_failed++;
      $display("FAIL overlong: wr=%0d wadr=%h wdata=%h required 1 5a c3", wr_seen - w0, icb_wadr, icb_wdata);
    end
    $display("[TB] overlong 22-bit write done");
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rx;
    logic bl, ol;
    int w0;
    spi_csn = 1'b0;
    #(SH);
    for (int i = 0; i < 6; i++) begin
      spi_mosi = i[0];
      #(SH); spi_sclk = 1'b1; #(SH); spi_sclk = 1'b0;
    end
    rst_n = 1'b0;
    #30;
    tests_run++;
    if ({spi_miso, spi_miso_oe, icb_wr, icb_rd, busy} !== 5'b0 || {icb_wadr, icb_wdata, icb_radr} !== 24'h0) begin
      tests_failed++;
      $display("FAIL midframe_reset_outs: ctrl=%b wadr=%h wdata=%h radr=%h required all 0",
               {spi_miso, spi_miso_oe, icb_wr, icb_rd, busy}, icb_wadr, icb_wdata, icb_radr);
    end
    rst_n = 1'b1;
    // Finish the interrupted frame with csn still low; the block must ignore it.
    for (int i = 0; i < 11; i++) begin
      spi_mosi = 1'b1;
      #(SH); spi_sclk = 1'b1; #(SH); spi_sclk = 1'b0;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_ignored: busy=%b required 0", busy);
    end
    #(SH); spi_csn = 1'b1; spi_mosi = 1'b0; #(4*SH);
    w0 = wr_seen;
    exp_q.push_back('{is_rd: 1'b0, adr: 8'h01, data: 8'h7E});
    spi_xfer({15'h0, 1'b0, 8'h01, 8'h7E}, 17, 4*SH, rx, bl, ol);
    tests_run++;
    if (wr_seen - w0 !== 1 || icb_wadr !== 8'h01 || icb_wdata !== 8'h7E) begin
      tests_failed++;
      $display("FAIL midframe_recover: wr=%0d wadr=%h wdata=%h required 1 01 7e", wr_seen - w0, icb_wadr, icb_wdata);
    end
    $display("[TB] reset mid-frame then write 01/7e done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx;
    logic bl, ol;
    int w0, r0;
    w0 = wr_seen; r0 = rd_seen;
    rdata_value = 8'hE1;
    exp_q.push_back('{is_rd: 1'b0, adr: 8'h33, data: 8'h99});
    exp_q.push_back('{is_rd: 1'b1, adr: 8'h44, data: 8'hE1});
    spi_xfer({15'h0, 1'b0, 8'h33, 8'h99}, 17, 4*SH, rx, bl, ol);
    spi_xfer({15'h0, 1'b1, 8'h44, 8'h00}, 17, 4*SH, rx, bl, ol);
    tests_run++;
    if (wr_seen - w0 !== 1 || rd_seen - r0 !== 1 || rx[7:0] !== 8'hE1) begin
      tests_failed++;
      $display("FAIL back_to_back: wr=%0d rd=%0d miso=%h required 1 1 e1", wr_seen - w0, rd_seen - r0, rx[7:0]);
    end
    tests_run++;
    if (icb_wadr !== 8'h33 || icb_wdata !== 8'h99 || icb_radr !== 8'h44) begin
      tests_failed++;
      $display("FAIL back_to_back_hold: wadr=%h wdata=%h radr=%h required 33 99 44", icb_wadr, icb_wdata, icb_radr);
    end
    $display("[TB] back-to-back write/read done");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read(8'h10, 8'h3C);
    test_abort(10);
    test_abort(5);
    test_overlong();
    test_reset_midframe();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL pending_strobes: %0d left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_icb_bridge.md
SPI_ICB_BRIDGE -- requirements
Module: spi_icb_bridge

Interface
REQ-001 SHALL have parameter aw, default 8, ICB address width.
REQ-002 SHALL have parameter dw, default 8, ICB data width.
REQ-003 SHALL have ports, one per line below:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- spi_sclk  input  1  SPI clock, mode 0, asynchronous to clk.
- spi_csn  input  1  SPI chip select, active low.
- spi_mosi  input  1  serial data in, MSB first.
- spi_miso  output  1  serial read data out, MSB first.
- spi_miso_oe  output  1  miso output enable.
- icb_wr  output  1  write strobe.
- icb_wadr  output  aw  write address.
- icb_wdata  output  dw  write data.
- icb_rd  output  1  read strobe.
- icb_radr  output  aw  read address.
- icb_rdata  input  dw  read data; valid one clk after icb_rd.
- busy  output  1  frame in progress.
REQ-004 Clocking and reset SHALL be one clock (clk) with asynchronous active-low reset (rst_n); no other clock domain exists inside the block.

Function
REQ-005 spi_sclk, spi_csn and spi_mosi SHALL each pass through a 2-flop synchronizer; sclk rise/fall are detected from synchronized samples; clk frequency SHALL be at least 8x sclk.
REQ-006 A frame SHALL be 1+aw+dw bits: rw bit (1=read), address MSB first, then data MSB first; bits are sampled on detected sclk rise.
REQ-007 FSM states SHALL be IDLE, ADDR, RDREQ, RDCAP, DATA, WRREQ, WAIT.
REQ-008 IDLE->ADDR SHALL occur on synchronized csn falling; busy SHALL be 1 in every state except IDLE.
REQ-009 ADDR SHALL go to RDREQ after the last address bit if rw=1, else to DATA.
REQ-010 RDREQ SHALL assert icb_rd for exactly one clk with icb_radr = received address, then go to RDCAP.
REQ-011 RDCAP SHALL capture icb_rdata in a shift register, drive its MSB on spi_miso, and go to DATA.
REQ-012 In a read DATA phase, spi_miso SHALL shift to the next bit on each detected sclk fall; mosi bits are ignored; after dw rises go to WAIT.
REQ-013 In a write DATA phase, after the dw-th rise go to WRREQ; WRREQ SHALL assert icb_wr for exactly one clk with icb_wadr/icb_wdata = received values, then go to WAIT.
REQ-014 WAIT SHALL ignore further sclk edges (overlong frames produce no extra strobe) until csn goes high, then go to IDLE.
REQ-015 Synchronized csn going high in ADDR or DATA SHALL abort to IDLE without any strobe.
REQ-016 Synchronized csn going high in RDREQ, RDCAP or WRREQ SHALL complete the strobe in progress, then go to IDLE.
REQ-017 icb_wr and icb_rd SHALL never be asserted in the same clk; at most one strobe SHALL occur per frame.
REQ-018 icb_wadr, icb_wdata and icb_radr SHALL hold their last strobed values until the next strobe.
REQ-019 spi_miso_oe SHALL be 1 only from RDCAP through WAIT of a read frame; when oe=0, spi_miso SHALL be 0.

Reset
REQ-020 On rst_n low, all outputs SHALL be 0, the FSM SHALL be IDLE, and shift registers, bit counter and synchronizers SHALL be cleared (synchronizer csn stages to 1).
REQ-021 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a fresh csn falling edge.

Configuration
REQ-022 With macro SPI_ICB_ABORT_CNT_EN defined, the block SHALL add output abort_cnt [7:0] that increments (saturating at 255) on each REQ-015 abort and is reset to 0; without the macro the port and its logic SHALL not exist.

Verification
REQ-023 Write frame rw=0, addr=0x25, data=0xA5 -> single 1-clk icb_wr, icb_wadr=0x25, icb_wdata=0xA5, icb_rd never asserted.
REQ-024 Read frame rw=1, addr=0x10, icb_rdata=0x3C -> single 1-clk icb_rd, icb_radr=0x10, miso bits 0,0,1,1,1,1,0,0 sampled on sclk rises.
REQ-025 csn raised after 10 bits -> no strobe, busy returns to 0, abort_cnt=1 (macro on).
REQ-026 Write frame of 22 sclk cycles -> exactly one icb_wr with the first 17 bits' values.
REQ-027 rst_n pulsed mid-frame, then a valid write addr=0x01 data=0x7E -> outputs 0 during reset, then one icb_wr with 0x01/0x7E.
REQ-028 Back-to-back write then read frames with csn high for 2 sclk periods -> one icb_wr then one icb_rd, each decoded correctly.
